// File: rtl/arb_client_req.sv
// Client-side initiator for the two-client req/ack arbiter: buffers request words in a
// small FIFO and issues them one at a time with a 4-phase req/ack handshake.
module arb_client_req #(
  parameter int REQ_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [REQ_DATA_WIDTH-1:0]     wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          wr_drop,
  output logic                          req,
  output logic [REQ_DATA_WIDTH-1:0]     data_req,
  input  logic                          ack,
  output logic                          done,
  output logic                          err_tmo
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ACKED = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  logic [REQ_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             rd_ptr_q;
  logic [CW-1:0]             count_q;
  logic [CW-1:0]             count_d;
  logic                      full_q;
  logic                      wr_drop_q;
  logic                      push;
  logic                      pop;

  state_t                    state_q;
  logic                      req_q;
  logic [REQ_DATA_WIDTH-1:0] data_req_q;
  logic                      done_q;
  logic                      err_tmo_q;
  logic [TW-1:0]             tmr_q;

  // Pop is the ACKED->GAP edge, i.e. the handshake's ack fall.
  always_comb begin
    push    = wr_en && !full_q;
    pop     = (state_q == S_ACKED) && !ack;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Storage array carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q   <= count_d;
      full_q    <= (count_d == DEPTH_C);
      wr_drop_q <= wr_en && full_q;
    end
  end

  // Handshake FSM; ack has priority over timeout when both land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      data_req_q <= '0;
      done_q     <= 1'b0;
      err_tmo_q  <= 1'b0;
      tmr_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      err_tmo_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q    <= S_REQ;
            req_q      <= 1'b1;
            data_req_q <= mem_q[rd_ptr_q];
            tmr_q      <= '0;
          end
        end
        S_REQ: begin
          if (ack) begin
            state_q <= S_ACKED;
          end else if ((TIMEOUT != 0) && (tmr_q == TMO_LAST)) begin
            state_q   <= S_GAP;
            req_q     <= 1'b0;
            err_tmo_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_ACKED: begin
          if (!ack) begin
            state_q <= S_GAP;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign count    = count_q;
  assign wr_drop  = wr_drop_q;
  assign req      = req_q;
  assign data_req = data_req_q;
  assign done     = done_q;
  assign err_tmo  = err_tmo_q;

endmodule

// File: tb/tb_arb_client_req.sv
// Self-checking bench for arb_client_req: directed handshake scenarios plus a randomized
// run scored against a queue-based transaction model.
module tb_arb_client_req;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int TMO = 8;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         wr_en   = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         ack     = 1'b0;
  logic         full;
  logic [2:0]   count;
  logic         wr_drop;
  logic         req;
  logic [W-1:0] data_req;
  logic         done;
  logic         err_tmo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arb_client_req #(
    .REQ_DATA_WIDTH(W),
    .FIFO_DEPTH    (D),
    .TIMEOUT       (TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .count   (count),
    .wr_drop (wr_drop),
    .req     (req),
    .data_req(data_req),
    .ack     (ack),
    .done    (done),
    .err_tmo (err_tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    ack   = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", req); end
    checks++; if (data_req !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", data_req); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if ({full, wr_drop, done, err_tmo} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {full, wr_drop, done, err_tmo});
    end
  endtask

  task automatic test_single();
    do_reset();
    wr_en = 1'b1; wr_data = 8'd21;
    step();
    wr_en = 1'b0;
    checks++; if (count !== 3'd1 || req !== 1'b0) begin
      errors++; $display("FAIL single_push: got count=%0d req=%0b want 1/0", count, req);
    end
    step();
    checks++; if (req !== 1'b1 || data_req !== 8'd21) begin
      errors++; $display("FAIL single_req: got req=%0b data=%0d want 1/21", req, data_req);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (req !== 1'b1 || data_req !== 8'd21) begin
        errors++; $display("FAIL single_hold: got req=%0b data=%0d want 1/21", req, data_req);
      end
    end
    ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (req !== 1'b1 || done !== 1'b0 || count !== 3'd1) begin
        errors++; $display("FAIL single_acked: got req=%0b done=%0b count=%0d want 1/0/1", req, done, count);
      end
    end
    ack = 1'b0;
    step();
    checks++; if (req !== 1'b0 || done !== 1'b1 || count !== 3'd0) begin
      errors++; $display("FAIL single_done: got req=%0b done=%0b count=%0d want 0/1/0", req, done, count);
    end
    step();
    checks++; if (req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL single_after: got req=%0b done=%0b want 0/0", req, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_w [4];
    logic [W-1:0] got[$];
    int           rise_at[$];
    int           dones    = 0;
    logic         prev_req = 1'b0;
    exp_w[0] = 8'd21; exp_w[1] = 8'd7; exp_w[2] = 8'd5; exp_w[3] = 8'd3;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      wr_en   = (i < 4);
      wr_data = exp_w[(i < 4) ? i : 0];
      ack     = req && !ack;
      step();
      if (req && !prev_req) begin
        got.push_back(data_req);
        rise_at.push_back(i);
      end
      if (done) dones++;
      prev_req = req;
    end
    wr_en = 1'b0;
    ack   = 1'b0;
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL b2b_nreq: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++; if (got[k] !== exp_w[k]) begin
        errors++; $display("FAIL b2b_data[%0d]: got %0d want %0d", k, got[k], exp_w[k]);
      end
    end
    for (int k = 1; k < rise_at.size(); k++) begin
      checks++; if (rise_at[k] - rise_at[k-1] !== 4) begin
        errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", k, rise_at[k] - rise_at[k-1]);
      end
    end
    checks++; if (dones !== 4) begin errors++; $display("FAIL b2b_done: got %0d want 4", dones); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_count: got %0d want 0", count); end
  endtask

  task automatic test_full();
    logic [W-1:0] v;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      v = W'(i);
      wr_en = 1'b1; wr_data = v;
      step();
      if (i < 5) begin
        checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL full_nodrop[%0d]: got %0b want 0", i, wr_drop); end
      end
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1 || count !== 3'd4) begin
      errors++; $display("FAIL full_state: got full=%0b count=%0d want 1/4", full, count);
    end
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL full_drop: got %0b want 1", wr_drop); end
    checks++; if (req !== 1'b1 || data_req !== 8'd1) begin
      errors++; $display("FAIL full_head: got req=%0b data=%0d want 1/1", req, data_req);
    end
    step();
    checks++; if (wr_drop !== 1'b0 || count !== 3'd4) begin
      errors++; $display("FAIL full_after: got drop=%0b count=%0d want 0/4", wr_drop, count);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    wr_en = 1'b1; wr_data = 8'd42;
    step();
    wr_en = 1'b0;
    step();
    for (int i = 0; i < 20 && req; i++) begin
      n++;
      step();
    end
    checks++; if (n !== TMO) begin errors++; $display("FAIL tmo_len: got %0d want %0d", n, TMO); end
    checks++; if (err_tmo !== 1'b1 || count !== 3'd1) begin
      errors++; $display("FAIL tmo_pulse: got err=%0b count=%0d want 1/1", err_tmo, count);
    end
    step();
    checks++; if (req !== 1'b0 || err_tmo !== 1'b0) begin
      errors++; $display("FAIL tmo_gap: got req=%0b err=%0b want 0/0", req, err_tmo);
    end
    step();
    checks++; if (req !== 1'b1 || data_req !== 8'd42 || count !== 3'd1) begin
      errors++; $display("FAIL tmo_retry: got req=%0b data=%0d count=%0d want 1/42/1", req, data_req, count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wr_en = 1'b1; wr_data = 8'd11;
    step();
    wr_data = 8'd22;
    step();
    wr_data = 8'd33; ack = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if (count !== 3'd3 || req !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got count=%0d req=%0b want 3/1", count, req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0 || count !== 3'd0 || full !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL arst_now: got req=%0b count=%0d full=%0b done=%0b want 0/0/0/0", req, count, full, done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ack = ~ack;
      step();
      checks++; if (req !== 1'b0 || done !== 1'b0 || count !== 3'd0) begin
        errors++; $display("FAIL arst_post[%0d]: got req=%0b done=%0b count=%0d want 0/0/0", i, req, done, count);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_stray_ack();
    do_reset();
    ack = 1'b1;
    step();
    step();
    ack = 1'b0;
    step();
    checks++; if (done !== 1'b0 || req !== 1'b0) begin
      errors++; $display("FAIL stray_idle: got done=%0b req=%0b want 0/0", done, req);
    end
    wr_en = 1'b1; wr_data = 8'd9;
    step();
    wr_en = 1'b0;
    step();
    checks++; if (req !== 1'b1 || data_req !== 8'd9) begin
      errors++; $display("FAIL stray_req: got req=%0b data=%0d want 1/9", req, data_req);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (req !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL stray_wait[%0d]: got req=%0b done=%0b want 1/0", i, req, done);
      end
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    checks++; if (done !== 1'b1 || count !== 3'd0 || req !== 1'b0) begin
      errors++; $display("FAIL stray_done: got done=%0b count=%0d req=%0b want 1/0/0", done, count, req);
    end
  endtask

  // Randomized traffic; the model is a word queue plus the handshake rules seen from the bus.
  task automatic test_random();
    logic [W-1:0] mq[$];
    logic [W-1:0] cur = '0;
    int  mode = 0;
    int  wait_cnt = 0, dly = 0, hold = 0, hcnt = 0, reqs = 0, low_left = 0;
    bit  e_done, e_tmo, e_drop, pop, must_rise = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      e_done = 1'b0; e_tmo = 1'b0; pop = 1'b0;
      if (mode == 1) begin
        if (wait_cnt >= dly) begin
          ack = 1'b1; hcnt = 1; mode = 2;
        end else begin
          ack = 1'b0; wait_cnt++;
          if (reqs == TMO) begin e_tmo = 1'b1; mode = 0; low_left = 2; end
        end
      end else if (mode == 2) begin
        if (hcnt < hold) begin
          ack = 1'b1; hcnt++;
        end else begin
          ack = 1'b0; pop = 1'b1; e_done = 1'b1; mode = 0; low_left = 2;
        end
      end else begin
        ack = 1'($urandom_range(0, 1));
      end
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = W'($urandom);
      e_drop  = wr_en && (mq.size() == D);
      step();
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (wr_en && !e_drop) mq.push_back(wr_data);

      checks++; if (count !== 3'(mq.size()) || full !== (mq.size() == D)) begin
        errors++; $display("FAIL rnd_count@%0d: got count=%0d full=%0b want %0d", cyc, count, full, mq.size());
      end
      checks++; if ({wr_drop, done, err_tmo} !== {e_drop, e_done, e_tmo}) begin
        errors++; $display("FAIL rnd_pulses@%0d: got drop/done/tmo=%b want %b", cyc, {wr_drop, done, err_tmo}, {e_drop, e_done, e_tmo});
      end
      if (low_left > 0) begin
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rnd_gap@%0d: got req=%0b want 0", cyc, req); end
        low_left--;
        must_rise = 1'b0;
      end else if (mode == 0) begin
        if (req) begin
          checks++; if (mq.size() == 0 || data_req !== mq[0]) begin
            errors++; $display("FAIL rnd_head@%0d: got data=%0d queue size=%0d", cyc, data_req, mq.size());
          end
          if (mq.size() > 0) cur = mq[0];
          mode = 1; wait_cnt = 0; reqs = 1;
          dly  = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 5);
          hold = $urandom_range(1, 3);
        end else begin
          checks++; if (must_rise) begin errors++; $display("FAIL rnd_norise@%0d: got req=0 want 1", cyc); end
        end
        must_rise = !req && (mq.size() > 0);
      end else begin
        checks++; if (req !== 1'b1 || data_req !== cur) begin
          errors++; $display("FAIL rnd_hold@%0d: got req=%0b data=%0d want 1/%0d", cyc, req, data_req, cur);
        end
        if (mode == 1) reqs++;
      end
    end
    wr_en = 1'b0;
    ack   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_timeout();
    test_async_reset();
    test_stray_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
